// File: rtl/clk_div_monitor.sv
// Period / high-time checker for a divided clock sampled in its source clock domain.
// Define CLKMON_DUTY_CHECK_EN to add high-time capture and the duty-cycle check.
module clk_div_monitor #(
  parameter int CNT_W      = 8,
  parameter int EXP_PERIOD = 3,
  parameter int EXP_HIGH   = 2,
  parameter int TOL        = 1,
  parameter int LOCK_N     = 4,
  parameter int TIMEOUT    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             div_clk,
  input  logic             clr_err,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_cnt,
  output logic             meas_valid,
  output logic             locked,
  output logic             err_period,
  output logic             err_duty,
  output logic             err_stuck
);

  localparam int GOOD_W = $clog2(LOCK_N + 1);
  localparam logic [CNT_W-1:0]  CNT_MAX      = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0]  EXP_PERIOD_C = CNT_W'(EXP_PERIOD);
  localparam logic [CNT_W-1:0]  TIMEOUT_C    = CNT_W'(TIMEOUT);
  localparam logic [GOOD_W-1:0] LOCK_C       = GOOD_W'(LOCK_N);

  typedef enum logic [1:0] {IDLE, WAIT_FALL, WAIT_RISE} state_t;

  state_t            state_reg, state_next;
  logic              sync1_reg, sync2_reg, samp_d_reg;
  logic [1:0]        fill_reg;
  logic [CNT_W-1:0]  cnt_reg;
  logic [GOOD_W-1:0] good_cnt_reg;
  logic              primed, rise, fall, timeout;
  logic              meas_evt, period_ok, duty_ok, good;

  // Edges are only trusted once all three sample flops hold real samples;
  // otherwise a high div_clk at reset release would look like a rise.
  assign primed  = (fill_reg == 2'd3);
  assign rise    = primed & sync2_reg & ~samp_d_reg;
  assign fall    = primed & ~sync2_reg & samp_d_reg;
  assign timeout = (cnt_reg == TIMEOUT_C) & ~rise;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_reg  <= 1'b0;
      sync2_reg  <= 1'b0;
      samp_d_reg <= 1'b0;
      fill_reg   <= 2'd0;
    end else begin
      sync1_reg  <= div_clk;
      sync2_reg  <= sync1_reg;
      samp_d_reg <= sync2_reg;
      if (fill_reg != 2'd3)
        fill_reg <= fill_reg + 2'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      cnt_reg <= '0;
    else if (rise)
      cnt_reg <= CNT_W'(1);
    else if (cnt_reg != CNT_MAX)
      cnt_reg <= cnt_reg + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      state_reg <= IDLE;
    else
      state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    meas_evt   = 1'b0;
    if (timeout) begin
      state_next = IDLE;
    end else begin
      case (state_reg)
        IDLE:      if (rise) state_next = WAIT_FALL;
        WAIT_FALL: if (fall) state_next = WAIT_RISE;
        WAIT_RISE: if (rise) begin
          meas_evt   = 1'b1;
          state_next = WAIT_FALL;
        end
        default:   state_next = IDLE;
      endcase
    end
  end

  assign period_ok = (cnt_reg == EXP_PERIOD_C);

`ifdef CLKMON_DUTY_CHECK_EN
  localparam logic [CNT_W-1:0] EXP_HIGH_C = CNT_W'(EXP_HIGH);
  localparam logic [CNT_W-1:0] TOL_C      = CNT_W'(TOL);

  logic [CNT_W-1:0] high_reg;

  assign duty_ok = (high_reg >= EXP_HIGH_C) ? ((high_reg - EXP_HIGH_C) <= TOL_C)
                                            : ((EXP_HIGH_C - high_reg) <= TOL_C);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      high_reg <= '0;
      high_cnt <= '0;
      err_duty <= 1'b0;
    end else begin
      if (state_reg == WAIT_FALL && fall && !timeout)
        high_reg <= cnt_reg;
      if (meas_evt)
        high_cnt <= high_reg;
      err_duty <= (meas_evt & ~duty_ok) | (err_duty & ~clr_err);
    end
  end
`else
  assign duty_ok  = 1'b1;
  assign high_cnt = '0;
  assign err_duty = 1'b0;
`endif

  assign good   = period_ok & duty_ok;
  assign locked = (good_cnt_reg == LOCK_C);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      period       <= '0;
      meas_valid   <= 1'b0;
      good_cnt_reg <= '0;
      err_period   <= 1'b0;
      err_stuck    <= 1'b0;
    end else begin
      meas_valid <= meas_evt;
      if (meas_evt)
        period <= cnt_reg;
      if (timeout)
        good_cnt_reg <= '0;
      else if (meas_evt) begin
        if (!good)
          good_cnt_reg <= '0;
        else if (good_cnt_reg != LOCK_C)
          good_cnt_reg <= good_cnt_reg + GOOD_W'(1);
      end
      // A new error event in the same cycle as clr_err keeps the flag set.
      err_period <= (meas_evt & ~period_ok) | (err_period & ~clr_err);
      err_stuck  <= timeout | (err_stuck & ~clr_err);
    end
  end

endmodule

// File: tb/tb_clk_div_monitor.sv
// Directed testbench for clk_div_monitor: lock, period/duty/stuck errors, clear and reset.
// Expectations for high_cnt/err_duty follow CLKMON_DUTY_CHECK_EN.
module tb_clk_div_monitor;

`ifdef CLKMON_DUTY_CHECK_EN
  localparam bit DUTY = 1'b1;
`else
  localparam bit DUTY = 1'b0;
`endif

  logic       clk;
  logic       rst;
  logic       div_clk;
  logic       clr_err;
  logic [7:0] period;
  logic [7:0] high_cnt;
  logic       meas_valid;
  logic       locked;
  logic       err_period;
  logic       err_duty;
  logic       err_stuck;

  int checks = 0;
  int errors = 0;

  // div_clk pattern generator; new lengths take effect at the next period start
  int hi_len = 2, lo_len = 1, nhi = 2, nlo = 1, phase = 0;
  bit gen_on = 1'b0, gen_level = 1'b0;

  clk_div_monitor dut (
    .clk(clk), .rst(rst), .div_clk(div_clk), .clr_err(clr_err),
    .period(period), .high_cnt(high_cnt), .meas_valid(meas_valid), .locked(locked),
    .err_period(err_period), .err_duty(err_duty), .err_stuck(err_stuck)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    div_clk = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (gen_on) begin
        if (phase == 0) begin
          hi_len = nhi;
          lo_len = nlo;
        end
        div_clk = (phase < hi_len);
        phase   = (phase + 1) % (hi_len + lo_len);
      end else begin
        phase   = 0;
        div_clk = gen_level;
      end
    end
  end

  function automatic logic [7:0] exp_high(input int h);
    return DUTY ? 8'(h) : 8'd0;
  endfunction

  task automatic set_pattern(input int h, input int l);
    nhi    = h;
    nlo    = l;
    gen_on = 1'b1;
  endtask

  task automatic wait_meas_n(input int n, output bit ok);
    int seen = 0;
    int cyc  = 0;
    while (seen < n && cyc < 40 * n) begin
      @(negedge clk);
      cyc++;
      if (meas_valid) seen++;
    end
    ok = (seen == n);
  endtask

  task automatic pulse_clr();
    @(negedge clk);
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if ({period, high_cnt, meas_valid, locked, err_period, err_duty, err_stuck} !== '0) begin
      errors++;
      $display("FAIL reset_state: outputs=%h required 0",
               {period, high_cnt, meas_valid, locked, err_period, err_duty, err_stuck});
    end
  endtask

  task automatic test_clean_lock();
    bit ok;
    set_pattern(2, 1);
    @(negedge clk);
    rst = 1'b1;
    wait_meas_n(1, ok);
    checks++;
    if (ok !== 1'b1) begin errors++; $display("FAIL clean_first_meas: got=%0b required 1", ok); end
    checks++;
    if (period !== 8'd3) begin errors++; $display("FAIL clean_period: got=%0d required 3", period); end
    checks++;
    if (high_cnt !== exp_high(2)) begin
      errors++; $display("FAIL clean_high: got=%0d required %0d", high_cnt, exp_high(2));
    end
    wait_meas_n(2, ok);
    checks++;
    if (locked !== 1'b0) begin errors++; $display("FAIL lock_after_3: got=%0b required 0", locked); end
    wait_meas_n(1, ok);
    checks++;
    if (locked !== 1'b1) begin errors++; $display("FAIL lock_after_4: got=%0b required 1", locked); end
    checks++;
    if ({err_period, err_duty, err_stuck} !== 3'b000) begin
      errors++; $display("FAIL clean_errs: got=%b required 000", {err_period, err_duty, err_stuck});
    end
  endtask

  task automatic test_period_err();
    bit ok;
    set_pattern(2, 2);
    wait_meas_n(3, ok);
    checks++;
    if (period !== 8'd4) begin errors++; $display("FAIL div4_period: got=%0d required 4", period); end
    checks++;
    if (err_period !== 1'b1) begin errors++; $display("FAIL div4_err_period: got=%0b required 1", err_period); end
    checks++;
    if (locked !== 1'b0) begin errors++; $display("FAIL div4_locked: got=%0b required 0", locked); end
    checks++;
    if (err_duty !== 1'b0) begin errors++; $display("FAIL div4_err_duty: got=%0b required 0", err_duty); end
    wait_meas_n(4, ok);
    checks++;
    if (locked !== 1'b0) begin errors++; $display("FAIL div4_stays_unlocked: got=%0b required 0", locked); end
  endtask

  task automatic test_clr_collision();
    bit ok;
    // Period 4 steady: the next evaluation edge is the 4th posedge after a meas_valid.
    wait_meas_n(1, ok);
    repeat (3) @(posedge clk);
    @(negedge clk);
    clr_err = 1'b1;
    @(posedge clk);
    #1 clr_err = 1'b0;
    @(negedge clk);
    checks++;
    if (meas_valid !== 1'b1) begin errors++; $display("FAIL collide_align: meas_valid=%0b required 1", meas_valid); end
    checks++;
    if (err_period !== 1'b1) begin errors++; $display("FAIL collide_set_wins: got=%0b required 1", err_period); end
  endtask

  task automatic test_stuck();
    bit ok;
    int since = 0;
    set_pattern(2, 1);
    wait_meas_n(8, ok);
    checks++;
    if (locked !== 1'b1) begin errors++; $display("FAIL relock: got=%0b required 1", locked); end
    pulse_clr();
    checks++;
    if (err_period !== 1'b0) begin errors++; $display("FAIL clr_period: got=%0b required 0", err_period); end
    wait_meas_n(1, ok);
    gen_on    = 1'b0;
    gen_level = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (meas_valid) since = 0;
      else since++;
      if (err_stuck) break;
    end
    checks++;
    if (err_stuck !== 1'b1) begin errors++; $display("FAIL stuck_flag: got=%0b required 1", err_stuck); end
    checks++;
    if (since !== 16) begin errors++; $display("FAIL stuck_timing: cycles=%0d required 16", since); end
    checks++;
    if (locked !== 1'b0) begin errors++; $display("FAIL stuck_locked: got=%0b required 0", locked); end
    set_pattern(2, 1);
    wait_meas_n(3, ok);
    checks++;
    if (locked !== 1'b0) begin errors++; $display("FAIL restart_lock_3: got=%0b required 0", locked); end
    wait_meas_n(1, ok);
    checks++;
    if (locked !== 1'b1) begin errors++; $display("FAIL restart_lock_4: got=%0b required 1", locked); end
    checks++;
    if (err_stuck !== 1'b1) begin errors++; $display("FAIL stuck_sticky: got=%0b required 1", err_stuck); end
    pulse_clr();
    checks++;
    if (err_stuck !== 1'b0) begin errors++; $display("FAIL clr_stuck: got=%0b required 0", err_stuck); end
  endtask

  task automatic test_duty();
    bit ok;
    set_pattern(5, 1);
    wait_meas_n(3, ok);
    checks++;
    if (period !== 8'd6) begin errors++; $display("FAIL duty_period: got=%0d required 6", period); end
    checks++;
    if (high_cnt !== exp_high(5)) begin
      errors++; $display("FAIL duty_high: got=%0d required %0d", high_cnt, exp_high(5));
    end
    checks++;
    if (err_period !== 1'b1) begin errors++; $display("FAIL duty_err_period: got=%0b required 1", err_period); end
    checks++;
    if (err_duty !== DUTY) begin errors++; $display("FAIL duty_err_duty: got=%0b required %0b", err_duty, DUTY); end
    set_pattern(1, 2);
    wait_meas_n(3, ok);
    pulse_clr();
    wait_meas_n(2, ok);
    checks++;
    if (period !== 8'd3) begin errors++; $display("FAIL tol_period: got=%0d required 3", period); end
    checks++;
    if (high_cnt !== exp_high(1)) begin
      errors++; $display("FAIL tol_high: got=%0d required %0d", high_cnt, exp_high(1));
    end
    checks++;
    if ({err_period, err_duty} !== 2'b00) begin
      errors++; $display("FAIL tol_errs: got=%b required 00", {err_period, err_duty});
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    int cyc = 0;
    set_pattern(2, 1);
    wait_meas_n(4, ok);
    wait_meas_n(1, ok);
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({period, high_cnt, meas_valid, locked, err_period, err_duty, err_stuck} !== '0) begin
      errors++;
      $display("FAIL async_reset: outputs=%h required 0",
               {period, high_cnt, meas_valid, locked, err_period, err_duty, err_stuck});
    end
    repeat (2) @(negedge clk);
    @(posedge clk);
    #3 rst = 1'b1;
    while (cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (meas_valid) break;
    end
    checks++;
    if (cyc < 4 || cyc >= 40) begin
      errors++; $display("FAIL post_reset_first_meas: cycle=%0d required 4..39", cyc);
    end
    checks++;
    if (period !== 8'd3) begin errors++; $display("FAIL post_reset_period: got=%0d required 3", period); end
    wait_meas_n(3, ok);
    checks++;
    if (locked !== 1'b1) begin errors++; $display("FAIL post_reset_lock: got=%0b required 1", locked); end
    checks++;
    if ({err_period, err_duty, err_stuck} !== 3'b000) begin
      errors++; $display("FAIL post_reset_errs: got=%b required 000", {err_period, err_duty, err_stuck});
    end
  endtask

  initial begin
    rst     = 1'b0;
    clr_err = 1'b0;
    test_reset();
    test_clean_lock();
    test_period_err();
    test_clr_collision();
    test_stuck();
    test_duty();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
